// File: rtl/game_sequencer_pkg.sv
// Shared game definitions: state codes and ball speed constants used by the
// sequencer, display and collision blocks.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } game_state_t;

    localparam logic [1:0] SPEED_STOP = 2'd0;
    localparam logic [1:0] SPEED_1    = 2'd1;
    localparam logic [1:0] SPEED_2    = 2'd2;
    localparam logic [1:0] SPEED_3    = 2'd3;

    localparam logic [6:0] SCORE_MAX  = 7'd99;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter, saturating at 99, with a binary copy of the
// score for threshold comparisons.
module bcd_score_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] score_bin
);

    logic at_max;

    assign at_max    = (tens == 4'd9) && (ones == 4'd9);
    // tens*10 as tens*8 + tens*2
    assign score_bin = ({3'd0, tens} << 3) + ({3'd0, tens} << 1) + {3'd0, ones};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc && !at_max) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow controller: serve/play/win/lose sequencing, lives,
// BCD score and ball speed phases. All outputs are registered.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int INIT_LIVES   = 3,
    parameter int PHASE2_SCORE = 20,
    parameter int PHASE3_SCORE = 40,
    parameter int WIN_SCORE    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       block_hit,
    input  logic       ball_lost,
    input  logic       all_cleared,
    output logic [2:0] state,
    output logic       run_en,
    output logic       ball_load,
    output logic       clear_blocks,
    output logic [1:0] ball_speed,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] lives
);

    localparam logic [3:0] LIVES_INIT = 4'(INIT_LIVES);
    localparam logic [6:0] PHASE2_BIN = 7'(PHASE2_SCORE);
    localparam logic [6:0] PHASE3_BIN = 7'(PHASE3_SCORE);
    localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

    function automatic logic [1:0] speed_for(input logic [6:0] s);
        if (s >= PHASE3_BIN)      return SPEED_3;
        else if (s >= PHASE2_BIN) return SPEED_2;
        else                      return SPEED_1;
    endfunction

    game_state_t cur_state, next_state;
    logic        start_q, start_pulse;
    logic        score_inc, score_clr;
    logic [6:0]  score_bin;
    logic [3:0]  lives_d;
    logic        run_en_d, ball_load_d, clear_blocks_d;
    logic [1:0]  ball_speed_d;

    assign start_pulse = start & ~start_q;
    assign state       = cur_state;

    bcd_score_counter u_score (
        .clk       (clk),
        .rst       (rst),
        .inc       (score_inc),
        .clr       (score_clr),
        .tens      (score_tens),
        .ones      (score_ones),
        .score_bin (score_bin)
    );

    always_comb begin
        next_state     = cur_state;
        lives_d        = lives;
        score_inc      = 1'b0;
        score_clr      = 1'b0;
        clear_blocks_d = 1'b0;
        case (cur_state)
            ST_IDLE: if (start_pulse) begin
                score_clr      = 1'b1;
                lives_d        = LIVES_INIT;
                clear_blocks_d = 1'b1;
                next_state     = ST_SERVE;
            end
            ST_SERVE: if (start_pulse) next_state = ST_PLAY;
            ST_PLAY: begin
                score_inc = block_hit;
                // A lost ball beats the win check; a hit in the same cycle still scores.
                if (ball_lost) begin
                    if (lives <= 4'd1) begin
                        lives_d    = 4'd0;
                        next_state = ST_LOSE;
                    end else begin
                        lives_d    = lives - 4'd1;
                        next_state = ST_SERVE;
                    end
                end else if ((score_bin >= WIN_BIN) || all_cleared) begin
                    next_state = ST_WIN;
                end
            end
            ST_WIN, ST_LOSE: if (start_pulse) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase

        run_en_d     = (next_state == ST_PLAY);
        ball_load_d  = (next_state == ST_IDLE) || (next_state == ST_SERVE);
        ball_speed_d = (next_state == ST_PLAY) ? speed_for(score_bin) : SPEED_STOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state    <= ST_IDLE;
            start_q      <= 1'b0;
            lives        <= LIVES_INIT;
            run_en       <= 1'b0;
            ball_load    <= 1'b1;
            clear_blocks <= 1'b0;
            ball_speed   <= SPEED_STOP;
        end else begin
            cur_state    <= next_state;
            start_q      <= start;
            lives        <= lives_d;
            run_en       <= run_en_d;
            ball_load    <= ball_load_d;
            clear_blocks <= clear_blocks_d;
            ball_speed   <= ball_speed_d;
        end
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter INIT_LIVES, default 3: lives loaded at game start (1..9).
REQ-002 SHALL have parameter PHASE2_SCORE, default 20: score at which ball speed becomes 2.
REQ-003 SHALL have parameter PHASE3_SCORE, default 40: score at which ball speed becomes 3.
REQ-004 SHALL have parameter WIN_SCORE, default 60: score at which the game is won.
REQ-005 SHALL have port clk, input, 1: game clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1: debounced start button level.
REQ-008 SHALL have port block_hit, input, 1: one-cycle pulse from the collision datapath, one block destroyed.
REQ-009 SHALL have port ball_lost, input, 1: one-cycle pulse, ball crossed the floor.
REQ-010 SHALL have port all_cleared, input, 1: level, no unhit blocks remain.
REQ-011 SHALL have port state, output, 3: current state code from the shared package.
REQ-012 SHALL have port run_en, output, 1: ball/paddle physics enabled.
REQ-013 SHALL have port ball_load, output, 1: hold the ball at its launch position.
REQ-014 SHALL have port clear_blocks, output, 1: one-cycle pulse that restores every block to unhit.
REQ-015 SHALL have port ball_speed, output, 2: pixels per tick (0..3).
REQ-016 SHALL have ports score_tens and score_ones, output, 4 each: BCD score.
REQ-017 SHALL have port lives, output, 4: remaining lives, binary.

Function
REQ-018 SHALL detect start rising edges with a registered copy of start; start_pulse = start & ~start_q; a held level SHALL NOT retrigger.
REQ-019 SHALL implement states IDLE, SERVE, PLAY, WIN, LOSE; all outputs registered.
REQ-020 IDLE: run_en=0, ball_load=1, speed=0; on start_pulse it SHALL, in the same clock edge, set score=00 and lives=INIT_LIVES, assert clear_blocks for exactly one cycle, and go to SERVE.
REQ-021 SERVE: run_en=0, ball_load=1, speed=0; on start_pulse it SHALL go to PLAY.
REQ-022 PLAY: run_en=1, ball_load=0; ball_speed SHALL be 1 below PHASE2_SCORE, 2 from PHASE2_SCORE up to PHASE3_SCORE-1, and 3 at or above PHASE3_SCORE, using the registered score.
REQ-023 In PLAY, each block_hit SHALL increment the BCD score by 1 (ones 9→0 with a tens carry), saturating at 99.
REQ-024 In PLAY, ball_lost SHALL decrement lives; if lives was 1, it SHALL go to LOSE with lives=0; otherwise it SHALL go to SERVE.
REQ-025 In PLAY, if there is no ball_lost and either the registered score ≥ WIN_SCORE or all_cleared=1, it SHALL go to WIN.
REQ-026 Priority: ball_lost SHALL take priority over the win check; a block_hit in the same cycle as ball_lost SHALL still be counted.
REQ-027 block_hit and ball_lost SHALL be ignored outside PLAY.
REQ-028 WIN/LOSE: run_en=0, ball_load=0, speed=0, score and lives held; on start_pulse it SHALL go to IDLE.
REQ-029 Lives SHALL never underflow below 0; score SHALL never exceed 99.

Reset
REQ-030 On rst: state=IDLE, start_q=0, score_tens=score_ones=0, lives=INIT_LIVES, run_en=0, ball_load=1, clear_blocks=0, ball_speed=0.
REQ-031 rst asserted mid-game SHALL abort to IDLE immediately, with no clear_blocks pulse until the next start.

Structure
REQ-032 State codes (IDLE=0, SERVE=1, PLAY=2, WIN=3, LOSE=4) and speed constants SHALL live in the shared game package, also used by the display and collision blocks.
REQ-033 The BCD score SHALL be a sub-module bcd_score_counter (inc, clr, saturation at 99, outputs tens/ones plus a 7-bit binary score for threshold compares).

Verification
REQ-034 Reset, then start pulse → clear_blocks high exactly 1 cycle, state SERVE, lives=3, score=00; second start pulse → PLAY, run_en=1, speed=1.
REQ-035 In PLAY, 20 block_hit pulses → score 2/0, speed=2 the following cycle; 20 more → 4/0, speed=3; 20 more → WIN, run_en=0.
REQ-036 Three ball_lost pulses with start between → lives 2 (SERVE), 1 (SERVE), then LOSE with lives=0; further ball_lost → lives stays 0.
REQ-037 block_hit and ball_lost in the same PLAY cycle at score 09, lives 2 → score 10, lives 1, state SERVE.
REQ-038 Hold start high for 100 cycles from IDLE → exactly one transition, to SERVE; block_hit in SERVE → score unchanged.
REQ-039 In PLAY with score 33, assert rst → next sampled state IDLE, score 00, lives 3, clear_blocks 0; all_cleared=1 in PLAY → WIN.
